// File: rtl/otter_operand_stage_if.sv
// Bundle of the operand stage's decode, register-file, forwarding and ID/EX signals.
// The stage itself uses the slave view; the surrounding pipeline uses the master view.
interface otter_operand_stage_if #(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5,
  parameter int CNT_W   = 16
);
  logic               id_valid;
  logic [XLEN-1:0]    id_pc;
  logic [RADDR_W-1:0] id_rs1;
  logic [RADDR_W-1:0] id_rs2;
  logic               id_uses_rs1;
  logic               id_uses_rs2;
  logic [RADDR_W-1:0] id_rd;
  logic               id_regwrite;
  logic               id_is_load;
  logic [RADDR_W-1:0] rf_read1;
  logic [RADDR_W-1:0] rf_read2;
  logic [XLEN-1:0]    rf_data1;
  logic [XLEN-1:0]    rf_data2;
  logic [RADDR_W-1:0] mem_rd;
  logic               mem_regwrite;
  logic               mem_is_load;
  logic [XLEN-1:0]    mem_result;
  logic [RADDR_W-1:0] wb_rd;
  logic               wb_regwrite;
  logic [XLEN-1:0]    wb_data;
  logic               ex_ready;
  logic               flush;
  logic               id_stall;
  logic               ex_valid;
  logic [XLEN-1:0]    ex_pc;
  logic [XLEN-1:0]    ex_op1;
  logic [XLEN-1:0]    ex_op2;
  logic [RADDR_W-1:0] ex_rd;
  logic               ex_regwrite;
  logic               ex_is_load;
  logic [CNT_W-1:0]   stall_cnt;

  modport master (
    output id_valid, id_pc, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_rd,
           id_regwrite, id_is_load, rf_data1, rf_data2, mem_rd, mem_regwrite,
           mem_is_load, mem_result, wb_rd, wb_regwrite, wb_data, ex_ready, flush,
    input  rf_read1, rf_read2, id_stall, ex_valid, ex_pc, ex_op1, ex_op2, ex_rd,
           ex_regwrite, ex_is_load, stall_cnt
  );

  modport slave (
    input  id_valid, id_pc, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_rd,
           id_regwrite, id_is_load, rf_data1, rf_data2, mem_rd, mem_regwrite,
           mem_is_load, mem_result, wb_rd, wb_regwrite, wb_data, ex_ready, flush,
    output rf_read1, rf_read2, id_stall, ex_valid, ex_pc, ex_op1, ex_op2, ex_rd,
           ex_regwrite, ex_is_load, stall_cnt
  );
endinterface

// File: rtl/otter_operand_stage.sv
// OTTER decode-side operand stage: RF addressing, MEM/WB forwarding, load-use
// hazard bubbles and the ID/EX pipeline register.
module otter_operand_stage #(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5,
  parameter int CNT_W   = 16
) (
  input logic            clock,
  input logic            reset,
  otter_operand_stage_if.slave bus
);

  logic               ex_valid_reg;
  logic [XLEN-1:0]    ex_pc_reg;
  logic [XLEN-1:0]    ex_op1_reg;
  logic [XLEN-1:0]    ex_op2_reg;
  logic [RADDR_W-1:0] ex_rd_reg;
  logic               ex_regwrite_reg;
  logic               ex_is_load_reg;
  logic [CNT_W-1:0]   stall_cnt_reg;

  logic [RADDR_W-1:0] src     [2];
  logic [XLEN-1:0]    rf_data [2];
  logic               uses    [2];
  logic [XLEN-1:0]    op_next [2];
  logic [1:0]         src_hz;
  logic               hz;
  logic               ex_busy;

  assign src[0]     = bus.id_rs1;
  assign src[1]     = bus.id_rs2;
  assign rf_data[0] = bus.rf_data1;
  assign rf_data[1] = bus.rf_data2;
  assign uses[0]    = bus.id_uses_rs1;
  assign uses[1]    = bus.id_uses_rs2;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
      logic src_zero;
      logic mem_hit;
      logic wb_hit;
      logic ex_load_hit;

      assign src_zero    = (src[gi] == '0);
      assign mem_hit     = bus.mem_regwrite && (bus.mem_rd == src[gi]);
      assign wb_hit      = bus.wb_regwrite && (bus.wb_rd == src[gi]);
      assign ex_load_hit = ex_valid_reg && ex_regwrite_reg && ex_is_load_reg &&
                           (ex_rd_reg == src[gi]);

      // MEM is younger than WB, so its value shadows a WB match on the same register.
      assign op_next[gi] = src_zero ? '0 :
                           mem_hit  ? bus.mem_result :
                           wb_hit   ? bus.wb_data :
                                      rf_data[gi];

      // A load's data is unavailable while it sits in EX or MEM.
      assign src_hz[gi] = uses[gi] && !src_zero &&
                          (ex_load_hit || (mem_hit && bus.mem_is_load));
    end
  endgenerate

  assign hz      = bus.id_valid && (|src_hz);
  assign ex_busy = ex_valid_reg && !bus.ex_ready;

  assign bus.rf_read1 = bus.id_rs1;
  assign bus.rf_read2 = bus.id_rs2;
  assign bus.id_stall = bus.id_valid && (hz || ex_busy) && !bus.flush;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ex_valid_reg    <= 1'b0;
      ex_pc_reg       <= '0;
      ex_op1_reg      <= '0;
      ex_op2_reg      <= '0;
      ex_rd_reg       <= '0;
      ex_regwrite_reg <= 1'b0;
      ex_is_load_reg  <= 1'b0;
      stall_cnt_reg   <= '0;
    end else if (bus.flush) begin
      ex_valid_reg    <= 1'b0;
      ex_regwrite_reg <= 1'b0;
    end else if (ex_busy) begin
      ex_valid_reg    <= ex_valid_reg;
    end else if (hz) begin
      ex_valid_reg    <= 1'b0;
      ex_regwrite_reg <= 1'b0;
      if (stall_cnt_reg != '1) begin
        stall_cnt_reg <= stall_cnt_reg + 1'b1;
      end
    end else begin
      ex_valid_reg    <= bus.id_valid;
      ex_pc_reg       <= bus.id_pc;
      ex_op1_reg      <= op_next[0];
      ex_op2_reg      <= op_next[1];
      ex_rd_reg       <= bus.id_rd;
      ex_regwrite_reg <= bus.id_regwrite && bus.id_valid;
      ex_is_load_reg  <= bus.id_is_load;
    end
  end

  assign bus.ex_valid    = ex_valid_reg;
  assign bus.ex_pc       = ex_pc_reg;
  assign bus.ex_op1      = ex_op1_reg;
  assign bus.ex_op2      = ex_op2_reg;
  assign bus.ex_rd       = ex_rd_reg;
  assign bus.ex_regwrite = ex_regwrite_reg;
  assign bus.ex_is_load  = ex_is_load_reg;
  assign bus.stall_cnt   = stall_cnt_reg;

endmodule

// File: tb/tb_otter_operand_stage.sv
// Directed bench for otter_operand_stage: a per-cycle reference model checked at every
// falling edge, plus hand-computed expectations at the interesting points.
module tb_otter_operand_stage;

  localparam int XLEN    = 32;
  localparam int RADDR_W = 5;
  localparam int CNT_W   = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic clock;
  logic reset;
  bit   checking;
  int   tests_run;
  int   tests_failed;

  otter_operand_stage_if #(.XLEN(XLEN), .RADDR_W(RADDR_W), .CNT_W(CNT_W)) bus ();

  otter_operand_stage #(.XLEN(XLEN), .RADDR_W(RADDR_W), .CNT_W(CNT_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Reference model: what the ID/EX register must hold after each edge.
  logic             m_valid, m_rw, m_ld;
  logic [XLEN-1:0]  m_pc, m_op1, m_op2;
  logic [4:0]       m_rd;
  logic [CNT_W-1:0] m_cnt;

  function automatic logic [XLEN-1:0] operand(input logic [4:0] s, input logic [XLEN-1:0] rf);
    if (s == 5'd0) return '0;
    if (bus.mem_regwrite && bus.mem_rd == s) return bus.mem_result;
    if (bus.wb_regwrite && bus.wb_rd == s) return bus.wb_data;
    return rf;
  endfunction

  function automatic bit waits_on_load(input logic [4:0] s, input logic used);
    bit in_ex, in_mem;
    in_ex  = m_valid && m_rw && m_ld && (m_rd == s);
    in_mem = bus.mem_regwrite && bus.mem_is_load && (bus.mem_rd == s);
    return used && (s != 5'd0) && (in_ex || in_mem);
  endfunction

  function automatic bit model_hz();
    return bus.id_valid && (waits_on_load(bus.id_rs1, bus.id_uses_rs1) ||
                            waits_on_load(bus.id_rs2, bus.id_uses_rs2));
  endfunction

  function automatic bit model_stall();
    return bus.id_valid && (model_hz() || (m_valid && !bus.ex_ready)) && !bus.flush;
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_valid <= 1'b0; m_rw <= 1'b0; m_ld <= 1'b0;
      m_pc <= '0; m_op1 <= '0; m_op2 <= '0; m_rd <= '0; m_cnt <= '0;
    end else if (bus.flush) begin
      m_valid <= 1'b0; m_rw <= 1'b0;
    end else if (m_valid && !bus.ex_ready) begin
      m_valid <= m_valid;
    end else if (model_hz()) begin
      m_valid <= 1'b0; m_rw <= 1'b0;
      if (m_cnt < CNT_MAX) m_cnt <= m_cnt + 1'b1;
    end else begin
      m_valid <= bus.id_valid;
      m_pc    <= bus.id_pc;
      m_op1   <= operand(bus.id_rs1, bus.rf_data1);
      m_op2   <= operand(bus.id_rs2, bus.rf_data2);
      m_rd    <= bus.id_rd;
      m_rw    <= bus.id_regwrite && bus.id_valid;
      m_ld    <= bus.id_is_load;
    end
  end

  task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (checking && !reset) begin
      check("model ex_valid",    32'(bus.ex_valid),    32'(m_valid));
      check("model ex_pc",       bus.ex_pc,            m_pc);
      check("model ex_op1",      bus.ex_op1,           m_op1);
      check("model ex_op2",      bus.ex_op2,           m_op2);
      check("model ex_rd",       32'(bus.ex_rd),       32'(m_rd));
      check("model ex_regwrite", 32'(bus.ex_regwrite), 32'(m_rw));
      check("model ex_is_load",  32'(bus.ex_is_load),  32'(m_ld));
      check("model stall_cnt",   32'(bus.stall_cnt),   32'(m_cnt));
      check("model id_stall",    32'(bus.id_stall),    32'(model_stall()));
      check("model rf_read1",    32'(bus.rf_read1),    32'(bus.id_rs1));
      check("model rf_read2",    32'(bus.rf_read2),    32'(bus.id_rs2));
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_fwd();
    bus.mem_rd = '0; bus.mem_regwrite = 1'b0; bus.mem_is_load = 1'b0; bus.mem_result = '0;
    bus.wb_rd  = '0; bus.wb_regwrite  = 1'b0; bus.wb_data = '0;
  endtask

  task automatic set_id(input logic [XLEN-1:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic u1, input logic u2, input logic [4:0] rd,
                        input logic rw, input logic ld);
    bus.id_valid = 1'b1; bus.id_pc = pc; bus.id_rs1 = rs1; bus.id_rs2 = rs2;
    bus.id_uses_rs1 = u1; bus.id_uses_rs2 = u2; bus.id_rd = rd;
    bus.id_regwrite = rw; bus.id_is_load = ld;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, tests_failed=%0d", tests_failed);
    $fatal(1, "watchdog");
  end

  initial begin
    tests_run = 0; tests_failed = 0; checking = 1'b0;
    reset = 1'b0;
    bus.id_valid = 1'b0; bus.id_pc = '0; bus.id_rs1 = '0; bus.id_rs2 = '0;
    bus.id_uses_rs1 = 1'b0; bus.id_uses_rs2 = 1'b0; bus.id_rd = '0;
    bus.id_regwrite = 1'b0; bus.id_is_load = 1'b0;
    bus.rf_data1 = 32'h1111_1111; bus.rf_data2 = 32'h2222_2222;
    bus.ex_ready = 1'b1; bus.flush = 1'b0;
    clear_fwd();
    #2 reset = 1'b1;
    #1;
    check("reset ex_valid",  32'(bus.ex_valid),  32'd0);
    check("reset stall_cnt", 32'(bus.stall_cnt), 32'd0);
    repeat (3) step();
    reset = 1'b0;
    checking = 1'b1;

    // add x5,x1,x2 then a consumer of x5 forwarded from MEM
    set_id(32'h100, 5'd1, 5'd2, 1, 1, 5'd5, 1, 0);
    step();
    check("add ex_valid", 32'(bus.ex_valid), 32'd1);
    check("add ex_pc",    bus.ex_pc,         32'h100);
    check("add ex_op1",   bus.ex_op1,        32'h1111_1111);
    check("add ex_rd",    32'(bus.ex_rd),    32'd5);
    set_id(32'h104, 5'd5, 5'd3, 1, 1, 5'd6, 1, 0);
    bus.mem_rd = 5'd5; bus.mem_regwrite = 1'b1; bus.mem_result = 32'h1234;
    #1 check("fwd no stall", 32'(bus.id_stall), 32'd0);
    step();
    check("fwd mem op1", bus.ex_op1, 32'h1234);
    check("fwd rf op2",  bus.ex_op2, 32'h2222_2222);

    // x0 never forwards
    set_id(32'h108, 5'd0, 5'd0, 1, 1, 5'd1, 1, 0);
    bus.mem_rd = 5'd0; bus.mem_result = 32'hDEAD;
    bus.wb_rd = 5'd0; bus.wb_regwrite = 1'b1; bus.wb_data = 32'hBEEF;
    step();
    check("x0 op1", bus.ex_op1, 32'h0);
    check("x0 op2", bus.ex_op2, 32'h0);

    // MEM shadows WB; WB used when MEM does not match
    set_id(32'h10C, 5'd6, 5'd4, 1, 1, 5'd1, 1, 0);
    bus.mem_rd = 5'd6; bus.mem_result = 32'hAAAA;
    bus.wb_rd = 5'd6; bus.wb_data = 32'hBBBB;
    step();
    check("mem over wb op1", bus.ex_op1, 32'hAAAA);
    bus.wb_rd = 5'd4;
    step();
    check("wb op2", bus.ex_op2, 32'hBBBB);
    bus.mem_rd = 5'd4; bus.mem_regwrite = 1'b0; bus.mem_result = 32'h7777;
    step();
    check("mem no write op2", bus.ex_op2, 32'hBBBB);
    clear_fwd();

    // lw x7 then add x8,x7,x7: two bubbles, then operands from WB
    set_id(32'h200, 5'd1, 5'd2, 1, 1, 5'd7, 1, 1);
    step();
    check("lw ex_is_load", 32'(bus.ex_is_load), 32'd1);
    set_id(32'h204, 5'd7, 5'd7, 1, 1, 5'd8, 1, 0);
    #1 check("lu stall ex", 32'(bus.id_stall), 32'd1);
    step();
    check("lu bubble1 valid", 32'(bus.ex_valid),  32'd0);
    check("lu bubble1 cnt",   32'(bus.stall_cnt), 32'd1);
    bus.mem_rd = 5'd7; bus.mem_regwrite = 1'b1; bus.mem_is_load = 1'b1; bus.mem_result = 32'h9999;
    #1 check("lu stall mem", 32'(bus.id_stall), 32'd1);
    step();
    check("lu bubble2 valid", 32'(bus.ex_valid),  32'd0);
    check("lu bubble2 cnt",   32'(bus.stall_cnt), 32'd2);
    clear_fwd();
    bus.wb_rd = 5'd7; bus.wb_regwrite = 1'b1; bus.wb_data = 32'hCAFE;
    #1 check("lu released", 32'(bus.id_stall), 32'd0);
    step();
    check("lu ex_valid", 32'(bus.ex_valid), 32'd1);
    check("lu ex_pc",    bus.ex_pc,         32'h204);
    check("lu op1",      bus.ex_op1,        32'hCAFE);
    check("lu op2",      bus.ex_op2,        32'hCAFE);
    clear_fwd();

    // load followed by an independent instruction (rs1=x7 but unused): no bubble
    set_id(32'h208, 5'd1, 5'd2, 1, 1, 5'd7, 1, 1);
    step();
    set_id(32'h20C, 5'd7, 5'd3, 0, 1, 5'd9, 1, 0);
    #1 check("nodep no stall", 32'(bus.id_stall), 32'd0);
    step();
    check("nodep ex_pc", bus.ex_pc,             32'h20C);
    check("nodep cnt",   32'(bus.stall_cnt),    32'd2);

    // EX back-pressure holds ID/EX for three cycles
    set_id(32'h300, 5'd1, 5'd2, 1, 1, 5'd3, 1, 0);
    bus.ex_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 check("busy id_stall", 32'(bus.id_stall), 32'd1);
      step();
      check("busy ex_pc hold", bus.ex_pc, 32'h20C);
    end
    bus.ex_ready = 1'b1;
    step();
    check("busy released pc", bus.ex_pc, 32'h300);

    // flush during a load-use stall
    set_id(32'h400, 5'd1, 5'd2, 1, 1, 5'd7, 1, 1);
    step();
    set_id(32'h404, 5'd7, 5'd0, 1, 0, 5'd8, 1, 0);
    step();
    check("pre-flush cnt", 32'(bus.stall_cnt), 32'd3);
    bus.mem_rd = 5'd7; bus.mem_regwrite = 1'b1; bus.mem_is_load = 1'b1;
    bus.flush = 1'b1;
    #1 check("flush id_stall", 32'(bus.id_stall), 32'd0);
    step();
    check("flush ex_valid", 32'(bus.ex_valid),  32'd0);
    check("flush cnt",      32'(bus.stall_cnt), 32'd3);
    bus.flush = 1'b0;

    // counter saturates at all-ones
    bus.mem_rd = 5'd9;
    set_id(32'h500, 5'd9, 5'd0, 1, 0, 5'd1, 1, 0);
    repeat (15) step();
    check("cnt saturate", 32'(bus.stall_cnt), 32'(CNT_MAX));

    // asynchronous reset while stalled, then a normal load
    #3 reset = 1'b1;
    #1;
    check("async ex_valid",  32'(bus.ex_valid),  32'd0);
    check("async stall_cnt", 32'(bus.stall_cnt), 32'd0);
    check("async ex_op1",    bus.ex_op1,         32'd0);
    repeat (3) step();
    clear_fwd();
    set_id(32'h600, 5'd1, 5'd2, 1, 1, 5'd4, 1, 0);
    reset = 1'b0;
    step();
    check("post-reset valid", 32'(bus.ex_valid), 32'd1);
    check("post-reset pc",    bus.ex_pc,         32'h600);
    bus.id_valid = 1'b0;
    step();
    step();

    checking = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
